// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the EX-stage multiply/divide unit
//
// Purpose: enums for the multiply/divide opcode, the forwarding select code
// and the iterative unit's FSM state, plus the per-operation iteration count.
package mips_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    FW_IDEX = 2'b00,
    FW_WB   = 2'b01,
    FW_MEM  = 2'b10
  } fw_src_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ITER = 2'b01,
    ST_FIX  = 2'b10
  } md_state_t;

  localparam int unsigned MD_ITERS = 32;

endpackage

// File: rtl/fw_operand_mux.sv
// rtl/fw_operand_mux.sv - forwarding operand select for one multiply/divide operand
//
// Purpose: picks the operand from ID/EX, MEM/WB or EX/MEM. The unused
// select code falls back to the register-file value.
// Ports:
//   i_sel         forwarding select code
//   i_id_ex       register-file operand
//   i_mem_wb      MEM/WB forwarded result
//   i_ex_mem      EX/MEM forwarded result
//   o_operand     selected operand
module fw_operand_mux
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  fw_src_t           i_sel,
  input  logic [WIDTH-1:0]  i_id_ex,
  input  logic [WIDTH-1:0]  i_mem_wb,
  input  logic [WIDTH-1:0]  i_ex_mem,
  output logic [WIDTH-1:0]  o_operand
);

  always_comb begin
    o_operand = i_id_ex;
    case (i_sel)
      FW_WB:   o_operand = i_mem_wb;
      FW_MEM:  o_operand = i_ex_mem;
      default: o_operand = i_id_ex;
    endcase
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
//
// Purpose: selects forwarded operands, runs a 32-cycle shift-add multiply or
// restoring divide on magnitudes, applies sign fixup and writes HI/LO.
// Also services MTHI/MTLO. busy stalls the front of the pipe.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, op                launch operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   mthi, mtlo               write operand A into HI / LO
//   flush                    abort current operation
//   fw_a_src, fw_b_src       operand forwarding selects
//   id_ex_a, id_ex_b         register-file operands
//   mem_wb_data, ex_mem_data forwarded results
//   busy, done               operation in flight / one-cycle result pulse
//   hi, lo                   architectural HI and LO
module ex_muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic              flush,
  input  logic [1:0]        fw_a_src,
  input  logic [1:0]        fw_b_src,
  input  logic [WIDTH-1:0]  id_ex_a,
  input  logic [WIDTH-1:0]  id_ex_b,
  input  logic [WIDTH-1:0]  mem_wb_data,
  input  logic [WIDTH-1:0]  ex_mem_data,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);

  localparam logic [4:0] LAST_ITER = 5'(MD_ITERS - 1);

  md_state_t          r_state, w_next;
  logic [4:0]         r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b_mag, r_a_raw, r_hi, r_lo;
  logic               r_div, r_div0, r_neg_q, r_neg_r, r_done;

  logic [WIDTH-1:0]   w_a, w_b, w_a_mag, w_b_mag;
  logic               w_signed, w_a_neg, w_b_neg;
  logic               w_accept_start, w_accept_move;
  logic [WIDTH:0]     w_add, w_trial;
  logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;

  fw_operand_mux #(.WIDTH(WIDTH)) u_mux_a (
    .i_sel     (fw_src_t'(fw_a_src)),
    .i_id_ex   (id_ex_a),
    .i_mem_wb  (mem_wb_data),
    .i_ex_mem  (ex_mem_data),
    .o_operand (w_a)
  );

  fw_operand_mux #(.WIDTH(WIDTH)) u_mux_b (
    .i_sel     (fw_src_t'(fw_b_src)),
    .i_id_ex   (id_ex_b),
    .i_mem_wb  (mem_wb_data),
    .i_ex_mem  (ex_mem_data),
    .o_operand (w_b)
  );

  // MULT and DIV have op[0]=0; unsigned variants skip sign handling.
  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & w_a[WIDTH-1];
  assign w_b_neg  = w_signed & w_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -w_a : w_a;
  assign w_b_mag  = w_b_neg ? -w_b : w_b;

  // flush suppresses any same-cycle request; start beats a move.
  assign w_accept_start = (r_state == ST_IDLE) && start && !flush;
  assign w_accept_move  = (r_state == ST_IDLE) && !start && !flush && (mthi || mtlo);

  // Shift-add step: multiplier sits in the low half and retires from bit 0.
  assign w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b_mag} : '0);
  assign w_mul_next = {w_add, r_acc[WIDTH-1:1]};

  // Restoring step: partial remainder high, quotient bits shift in at bit 0.
  assign w_trial    = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b_mag};
  assign w_div_next = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                     : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (start) w_next = ST_ITER;
        ST_ITER: if (r_cnt == LAST_ITER) w_next = ST_FIX;
        ST_FIX:  w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (r_state != ST_IDLE);
    done = r_done;
    hi   = r_hi;
    lo   = r_lo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_b_mag <= '0;
      r_a_raw <= '0;
      r_div   <= 1'b0;
      r_div0  <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == ST_FIX) && !flush;
      if (w_accept_start) begin
        r_cnt   <= '0;
        r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
        r_b_mag <= w_b_mag;
        r_a_raw <= w_a;
        r_div   <= op[1];
        r_div0  <= op[1] && (w_b == '0);
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
      end else if (w_accept_move) begin
        if (mthi) r_hi <= w_a;
        if (mtlo) r_lo <= w_a;
      end else if (r_state == ST_ITER) begin
        r_cnt <= r_cnt + 5'd1;
        r_acc <= r_div ? w_div_next : w_mul_next;
      end else if ((r_state == ST_FIX) && !flush) begin
        if (r_div0) begin
          r_lo <= '1;
          r_hi <= r_a_raw;
        end else if (r_div) begin
          r_lo <= w_quo;
          r_hi <= w_rem;
        end else begin
          r_hi <= w_prod[2*WIDTH-1:WIDTH];
          r_lo <= w_prod[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, mthi, mtlo, flush;
  logic [1:0]  op, fw_a_src, fw_b_src;
  logic [31:0] id_ex_a, id_ex_b, mem_wb_data, ex_mem_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  int test_cnt = 0;
  int fail_cnt = 0;
  int n_busy, n_done;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .mthi(mthi), .mtlo(mtlo),
    .flush(flush), .fw_a_src(fw_a_src), .fw_b_src(fw_b_src),
    .id_ex_a(id_ex_a), .id_ex_b(id_ex_b), .mem_wb_data(mem_wb_data),
    .ex_mem_data(ex_mem_data), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse start, count busy cycles up to the done pulse, check result.
  task automatic do_op(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'd33);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    tick();
    check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
    op = 2'b00; fw_a_src = 2'b00; fw_b_src = 2'b00;
    id_ex_a = '0; id_ex_b = '0; mem_wb_data = '0; ex_mem_data = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    // MULT -3 * 7 with forwarded operands
    op = 2'b00; fw_a_src = 2'b10; fw_b_src = 2'b01;
    ex_mem_data = 32'hFFFF_FFFD; mem_wb_data = 32'd7;
    do_op("mult_fw", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    fw_a_src = 2'b00; fw_b_src = 2'b00;
    op = 2'b11; id_ex_a = 32'd100; id_ex_b = 32'd7;
    do_op("divu_100_7", 32'd2, 32'd14);

    op = 2'b10; id_ex_a = 32'hFFFF_FFF9; id_ex_b = 32'd2;
    do_op("div_neg7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    op = 2'b10; id_ex_a = 32'h8000_0000; id_ex_b = 32'hFFFF_FFFF;
    do_op("div_ovf", 32'd0, 32'h8000_0000);

    op = 2'b11; id_ex_a = 32'd5; id_ex_b = 32'd0;
    do_op("divu_by0", 32'd5, 32'hFFFF_FFFF);

    op = 2'b10; id_ex_a = 32'hFFFF_FFF6; id_ex_b = 32'd0;
    do_op("div_by0", 32'hFFFF_FFF6, 32'hFFFF_FFFF);

    op = 2'b01; id_ex_a = 32'hFFFF_FFFF; id_ex_b = 32'd2;
    do_op("multu_big", 32'd1, 32'hFFFF_FFFE);

    op = 2'b00; id_ex_a = 32'hFFFF_FFFE; id_ex_b = 32'hFFFF_FFFD;
    do_op("mult_negneg", 32'd0, 32'd6);

    // start with mthi: start wins, move dropped
    op = 2'b11; id_ex_a = 32'd100; id_ex_b = 32'd7; mthi = 1'b1;
    do_op("start_beats_mthi", 32'd2, 32'd14);

    // Second start at cycle 5 ignored
    op = 2'b11; id_ex_a = 32'd45; id_ex_b = 32'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    op = 2'b01; id_ex_a = 32'd50;
    n_busy = 0; n_done = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (busy) n_busy++;
      if (done) n_done++;
      start = (cyc == 5);
      tick();
    end
    start = 1'b0;
    check("restart_busy_cycles", 32'(n_busy), 32'd33);
    check("restart_done_count", 32'(n_done), 32'd1);
    check("restart_hi", hi, 32'd1);
    check("restart_lo", lo, 32'd11);

    // Flush at cycle 10
    op = 2'b00; id_ex_a = 32'd3; id_ex_b = 32'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < 10; cyc++) tick();
    check("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy_after", {31'd0, busy}, 32'd0);
    n_done = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (done) n_done++;
      tick();
    end
    check("flush_no_done", 32'(n_done), 32'd0);
    check("flush_hi_kept", hi, 32'd1);
    check("flush_lo_kept", lo, 32'd11);

    // flush in IDLE suppresses start
    start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_idle_start", {31'd0, busy}, 32'd0);

    // MTHI via code 11 (ID/EX), MTLO via MEM/WB
    fw_a_src = 2'b11; id_ex_a = 32'h1234_5678; mthi = 1'b1;
    tick();
    mthi = 1'b0;
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_done", {31'd0, done}, 32'd0);
    check("mthi_lo_kept", lo, 32'd11);
    fw_a_src = 2'b01; mem_wb_data = 32'hCAFE_0001; mtlo = 1'b1;
    tick();
    mtlo = 1'b0;
    check("mtlo_lo", lo, 32'hCAFE_0001);
    check("mtlo_hi_kept", hi, 32'h1234_5678);
    check("mtlo_busy", {31'd0, busy}, 32'd0);

    // Reset at cycle 20 of a MULTU
    fw_a_src = 2'b00; op = 2'b01; id_ex_a = 32'd3; id_ex_b = 32'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < 20; cyc++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    op = 2'b11; id_ex_a = 32'd100; id_ex_b = 32'd7;
    do_op("after_rst_divu", 32'd2, 32'd14);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

EX-stage iterative multiply/divide unit for the five-stage MIPS pipeline. It sits directly downstream of the forwarding unit: it consumes the two 2-bit forward-select codes, picks each operand from the ID/EX, MEM/WB or EX/MEM value, and then runs MULT/MULTU/DIV/DIVU over 33 cycles into architectural HI/LO. While it is busy it raises `busy`, which the hazard logic uses to stall the front of the pipe. It also services MTHI/MTLO writes and drives HI/LO for MFHI/MFLO.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `clk` input 1: single clock; every state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin the operation given by `op`; honoured only in IDLE.
- `op` input 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `mthi`, `mtlo` input 1 each: write the selected operand A into HI or LO; honoured only in IDLE.
- `flush` input 1: abort the current operation.
- `fw_a_src`, `fw_b_src` input 2 each: operand select. 00 selects ID/EX, 01 selects MEM/WB, 10 selects EX/MEM, 11 selects ID/EX.
- `id_ex_a`, `id_ex_b` input `WIDTH`: register-file operands.
- `mem_wb_data`, `ex_mem_data` input `WIDTH`: forwarded results.
- `busy` output 1: operation in flight.
- `done` output 1: one-cycle pulse marking new HI/LO.
- `hi`, `lo` output `WIDTH`: architectural HI and LO registers.

## Operation
- Operand muxes are combinational and are sampled only on the accepted `start`, `mthi` or `mtlo` cycle.
- States:
  - IDLE moves to ITER on `start`.
  - ITER runs 32 cycles, one bit per cycle, counted by a 5-bit counter, then moves to FIX.
  - FIX moves to IDLE and writes HI/LO.
- Multiply:
  - Shift-add on operand magnitudes into a 64-bit product.
  - MULT negates the product when the operand signs differ.
  - Result goes to HI = product[63:32], LO = product[31:0].
- Divide:
  - Restoring division on magnitudes.
  - For DIV, the quotient is negated when the signs differ, and the remainder takes the sign of the dividend.
  - Result goes to LO = quotient, HI = remainder.
- Divide by zero (DIV or DIVU), with no trap: LO = all ones and HI = dividend as selected, with no sign fixup.
- DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000 and HI = 0 (wraps, with no flag).
- MULTU and DIVU treat both operands as unsigned.
- Ignored requests:
  - `start`, `mthi` or `mtlo` arriving while busy is ignored; the pipeline has to hold the instruction.
  - `start` together with `mthi` or `mtlo` in IDLE: `start` wins and the move is dropped.
- `flush` has priority over everything except `rst`:
  - Return to IDLE on the next edge.
  - HI/LO are left unchanged and `done` is not pulsed.
  - In IDLE, `flush` suppresses a same-cycle `start`, `mthi` or `mtlo`.
- Reset: state IDLE, counter 0, `hi` = `lo` = 0, `busy` = 0, `done` = 0. Reset mid-operation aborts the operation the same way.

## Timing
- `start` is accepted at edge 0.
- `busy` is high in cycles 1 through 33 (32 ITER cycles and 1 FIX cycle).
- HI/LO are written at the end of cycle 33. `done` is high during cycle 34 with the new values visible, `busy` is low, and a new `start` is accepted in cycle 34.
- `busy` and `done` are registered; `hi` and `lo` come straight from their registers.
- MTHI/MTLO take effect at the next edge: the value is visible the cycle after and `done` is not pulsed.
- A `flush` that is high in cycle k drops `busy` in cycle k+1.

## Structure
- Shared package `mips_pkg` holds:
  - `muldiv_op_t`: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - `fw_src_t`: FW_IDEX=2'b00, FW_WB=2'b01, FW_MEM=2'b10.
  - The localparam giving the iteration count (32).
- Sub-module `fw_operand_mux`, instantiated twice (operands A and B): `WIDTH`-bit 3:1 select keyed on `fw_src_t`, with the unused code defaulting to ID/EX.
- The top level holds the FSM, the counter, the 64-bit accumulator/remainder register, the sign-fixup logic and HI/LO.

## Test plan
- MULT with `fw_a_src`=10 (`ex_mem_data` = 0xFFFFFFFD) and `fw_b_src`=01 (`mem_wb_data` = 7): `busy` is high for exactly 33 cycles, then `done` pulses with `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB.
- DIVU 100/7 from ID/EX gives `lo` = 14, `hi` = 2. DIV 0xFFFFFFF9/2 gives `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF gives `lo` = 0x80000000, `hi` = 0. DIVU 5/0 gives `lo` = 0xFFFFFFFF, `hi` = 5.
- Second `start` at cycle 5 of an operation is ignored, and only one `done` is seen. `flush` at cycle 10 makes `busy` low at cycle 11 with no `done`, and HI/LO keep their prior values.
- `mthi` with `fw_a_src`=11 and `id_ex_a` = 0x12345678: `hi` = 0x12345678 the next cycle, and `done` stays low.
- `rst` asserted at cycle 20 of a MULTU: the next cycle has `busy` = 0, `done` = 0, `hi` = `lo` = 0, and a subsequent `start` completes normally.
